pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types, widths and saturating helpers for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int ICP_W   = 6;
  localparam int LPF_W   = 3;
  localparam int ICP_MAX = 63;
  localparam int LPF_MAX = 7;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    LOCKED    = 3'd3,
    RETRY     = 3'd4,
    FAIL      = 3'd5
  } state_t;

  // Charge-pump select plus a step, clamped at the top code.
  function automatic logic [ICP_W-1:0] icp_step_sat(input logic [ICP_W-1:0] icp,
                                                     input int step);
    int sum;
    sum = int'(icp) + step;
    if (sum > ICP_MAX) begin
      return ICP_W'(ICP_MAX);
    end else begin
      return ICP_W'(sum);
    end
  endfunction

  // Loop-filter select plus one, clamped at the top code.
  function automatic logic [LPF_W-1:0] lpf_inc_sat(input logic [LPF_W-1:0] lpf);
    if (lpf == LPF_W'(LPF_MAX)) begin
      return lpf;
    end else begin
      return lpf + LPF_W'(1);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with synchronous clear.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the raw level, then re-time it once more before use.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier: holds the PLL in reset, waits for a
// stable lock, retries with stronger loop settings on timeout, and re-arms
// after a loss of lock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 4096,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int MAX_RETRIES      = 3,
  parameter int ICP_INIT         = 16,
  parameter int ICP_STEP         = 4,
  parameter int LPF_INIT         = 2
) (
  input  logic                                 init_clk,
  input  logic                                 reset,
  input  logic                                 restart,
  input  logic                                 pll_lock,
  output logic                                 pll_rst,
  output logic [ICP_W-1:0]                     icpsel,
  output logic [LPF_W-1:0]                     lpfres,
  output logic                                 lock,
  output logic                                 fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
  output logic [7:0]                           lost_cnt
);

  localparam int RC_W   = $clog2(MAX_RETRIES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYC) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYC) + 1;
  localparam int STB_W  = $clog2(LOCK_STABLE_CYC) + 1;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic [STB_W-1:0]    stb_cnt, stb_nxt;
  logic [ICP_W-1:0]    icp_nxt;
  logic [LPF_W-1:0]    lpf_nxt;
  logic [RC_W-1:0]     rc_nxt;
  logic [7:0]          lost_nxt;
  logic                lock_s;
  logic                tmo_hit;

  sync_2ff u_sync (
    .clk (init_clk),
    .clr (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign tmo_hit = (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1));

  // Next-state and next-setting decode; restart overrides every state.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    tmo_nxt   = tmo_cnt;
    stb_nxt   = stb_cnt;
    icp_nxt   = icpsel;
    lpf_nxt   = lpfres;
    rc_nxt    = retry_cnt;
    lost_nxt  = lost_cnt;
    if (restart) begin
      state_nxt = RST_HOLD;
      hold_nxt  = '0;
      tmo_nxt   = '0;
      stb_nxt   = '0;
      icp_nxt   = ICP_W'(ICP_INIT);
      lpf_nxt   = LPF_W'(LPF_INIT);
      rc_nxt    = '0;
    end else begin
      case (state)
        RST_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_HOLD_CYC - 1)) begin
            state_nxt = WAIT_LOCK;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        WAIT_LOCK, QUALIFY: begin
          if (tmo_hit) begin
            // Timeout wins over a qualification completing on the same edge.
            tmo_nxt = '0;
            stb_nxt = '0;
            if (retry_cnt < RC_W'(MAX_RETRIES)) begin
              state_nxt = RETRY;
              rc_nxt    = retry_cnt + RC_W'(1);
              if (icpsel == ICP_W'(ICP_MAX)) begin
                lpf_nxt = lpf_inc_sat(lpfres);
              end else begin
                icp_nxt = icp_step_sat(icpsel, ICP_STEP);
              end
            end else begin
              state_nxt = FAIL;
            end
          end else begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
            if (!lock_s) begin
              state_nxt = WAIT_LOCK;
              stb_nxt   = '0;
            end else if (state == WAIT_LOCK) begin
              state_nxt = QUALIFY;
              stb_nxt   = '0;
            end else if (stb_cnt == STB_W'(LOCK_STABLE_CYC - 1)) begin
              state_nxt = LOCKED;
              stb_nxt   = '0;
              tmo_nxt   = '0;
            end else begin
              stb_nxt = stb_cnt + STB_W'(1);
            end
          end
        end
        RETRY: begin
          state_nxt = RST_HOLD;
          hold_nxt  = '0;
        end
        LOCKED: begin
          if (!lock_s) begin
            // Re-arm with the settings that last achieved lock.
            state_nxt = RST_HOLD;
            hold_nxt  = '0;
            rc_nxt    = '0;
            lost_nxt  = (lost_cnt == 8'hFF) ? lost_cnt : lost_cnt + 8'd1;
          end else begin
            state_nxt = LOCKED;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = RST_HOLD;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // State, counters and registered pin outputs derived from the next state.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      state     <= RST_HOLD;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      stb_cnt   <= '0;
      icpsel    <= ICP_W'(ICP_INIT);
      lpfres    <= LPF_W'(LPF_INIT);
      retry_cnt <= '0;
      lost_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      lock      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      tmo_cnt   <= tmo_nxt;
      stb_cnt   <= stb_nxt;
      icpsel    <= icp_nxt;
      lpfres    <= lpf_nxt;
      retry_cnt <= rc_nxt;
      lost_cnt  <= lost_nxt;
      pll_rst   <= (state_nxt == RST_HOLD) || (state_nxt == RETRY) || (state_nxt == FAIL);
      lock      <= (state_nxt == LOCKED);
      fail      <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: two instances (normal and saturating icpsel)
// checked every cycle against a timestamp-based reference model, plus
// directed latency/sequence checks.
module tb_pll_lock_supervisor;

  localparam int H    = 4;
  localparam int T    = 20;
  localparam int S    = 8;
  localparam int MR   = 2;
  localparam int STEP = 4;

  localparam int M_HOLD  = 0;
  localparam int M_SRCH  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_RETRY = 3;
  localparam int M_FAILD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, restart0, restart1, lk0, lk1;
  logic pll_rst0, pll_rst1, lock0, lock1, fail0, fail1;
  logic [5:0] icp0, icp1;
  logic [2:0] lpf0, lpf1;
  logic [1:0] rc0, rc1;
  logic [7:0] lost0, lost1;

  pll_lock_supervisor #(.RST_HOLD_CYC(H), .LOCK_TIMEOUT_CYC(T), .LOCK_STABLE_CYC(S),
    .MAX_RETRIES(MR), .ICP_INIT(16), .ICP_STEP(STEP), .LPF_INIT(2)) dut0 (
    .init_clk(clk), .reset(reset), .restart(restart0), .pll_lock(lk0),
    .pll_rst(pll_rst0), .icpsel(icp0), .lpfres(lpf0), .lock(lock0), .fail(fail0),
    .retry_cnt(rc0), .lost_cnt(lost0));

  pll_lock_supervisor #(.RST_HOLD_CYC(H), .LOCK_TIMEOUT_CYC(T), .LOCK_STABLE_CYC(S),
    .MAX_RETRIES(MR), .ICP_INIT(60), .ICP_STEP(STEP), .LPF_INIT(2)) dut1 (
    .init_clk(clk), .reset(reset), .restart(restart1), .pll_lock(lk1),
    .pll_rst(pll_rst1), .icpsel(icp1), .lpfres(lpf1), .lock(lock1), .fail(fail1),
    .retry_cnt(rc1), .lost_cnt(lost1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state, one slot per instance.
  int m_mode[2], m_att[2], m_rel[2], m_icp[2], m_lpf[2], m_rc[2], m_lost[2];
  int icp_init[2] = '{16, 60};
  bit samp[2][0:4095];

  int  lock0_rise = -1000;
  int  lock0_fall = -1000;
  logic prev_lock0 = 1'b0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] cycle %0d: observed %0d expected %0d", tag, d, cyc, obs, exp);
    end
  endtask

  // Synchronised lock as seen by the supervisor at edge e.
  function automatic bit ls(input int d, input int e);
    if (e < 2) return 1'b0;
    return samp[d][e-2];
  endfunction

  function automatic bit window_ones(input int d, input int e);
    for (int i = e - S; i <= e; i++) begin
      if (!ls(d, i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input int d, input bit rst, input bit rs);
    int e;
    e = cyc;
    if (rst) begin
      m_mode[d] = M_HOLD; m_att[d] = e; m_icp[d] = icp_init[d]; m_lpf[d] = 2;
      m_rc[d] = 0; m_lost[d] = 0;
    end else if (rs) begin
      m_mode[d] = M_HOLD; m_att[d] = e; m_icp[d] = icp_init[d]; m_lpf[d] = 2; m_rc[d] = 0;
    end else begin
      case (m_mode[d])
        M_HOLD: if (e == m_att[d] + H) begin m_mode[d] = M_SRCH; m_rel[d] = e; end
        M_SRCH: begin
          if (e == m_rel[d] + T) begin
            if (m_rc[d] < MR) begin
              m_rc[d]++;
              if (m_icp[d] == 63) m_lpf[d] = (m_lpf[d] < 7) ? m_lpf[d] + 1 : 7;
              else m_icp[d] = (m_icp[d] + STEP > 63) ? 63 : m_icp[d] + STEP;
              m_mode[d] = M_RETRY;
            end else begin
              m_mode[d] = M_FAILD;
            end
          end else if ((e - S >= m_rel[d] + 1) && window_ones(d, e)) begin
            m_mode[d] = M_LOCK;
          end
        end
        M_RETRY: begin m_mode[d] = M_HOLD; m_att[d] = e; end
        M_LOCK: if (!ls(d, e)) begin
          m_lost[d] = (m_lost[d] < 255) ? m_lost[d] + 1 : 255;
          m_rc[d] = 0; m_mode[d] = M_HOLD; m_att[d] = e;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input int d);
    bit e_rst;
    e_rst = (m_mode[d] == M_HOLD) || (m_mode[d] == M_RETRY) || (m_mode[d] == M_FAILD);
    chk("pll_rst",   d, (d == 0) ? pll_rst0 : pll_rst1, e_rst);
    chk("lock",      d, (d == 0) ? lock0 : lock1, (m_mode[d] == M_LOCK));
    chk("fail",      d, (d == 0) ? fail0 : fail1, (m_mode[d] == M_FAILD));
    chk("icpsel",    d, (d == 0) ? icp0 : icp1, m_icp[d]);
    chk("lpfres",    d, (d == 0) ? lpf0 : lpf1, m_lpf[d]);
    chk("retry_cnt", d, (d == 0) ? rc0 : rc1, m_rc[d]);
    chk("lost_cnt",  d, (d == 0) ? lost0 : lost1, m_lost[d]);
  endtask

  // One clock: drive inputs, update the model at the edge, compare 1 ns later.
  task automatic step(input bit l0, input bit l1, input bit rst, input bit rs0, input bit rs1);
    lk0 = l0; lk1 = l1; reset = rst; restart0 = rs0; restart1 = rs1;
    @(posedge clk);
    samp[0][cyc] = rst ? 1'b0 : l0;
    samp[1][cyc] = rst ? 1'b0 : l1;
    if (rst && cyc > 0) begin
      samp[0][cyc-1] = 1'b0;
      samp[1][cyc-1] = 1'b0;
    end
    model_edge(0, rst, rs0);
    model_edge(1, rst, rs1);
    #1;
    check_all(0);
    check_all(1);
    if (lock0 === 1'b1 && prev_lock0 === 1'b0) lock0_rise = cyc;
    if (lock0 === 1'b0 && prev_lock0 === 1'b1) lock0_fall = cyc;
    prev_lock0 = lock0;
    cyc++;
  endtask

  initial begin
    int n, k, m, r, icp_at1, icp_at2, run0, run1;
    bit v0, v1;
    lk0 = 1'b0; lk1 = 1'b0; reset = 1'b1; restart0 = 1'b0; restart1 = 1'b0;

    // Reset and reset values.
    repeat (3) step(0, 0, 1, 0, 0);
    chk("rst_pll_rst", 0, pll_rst0, 1'b1);
    chk("rst_icpsel", 0, icp0, 6'd16);
    chk("rst_lpfres", 0, lpf0, 3'd2);

    // Clean lock: pll_rst high for exactly H cycles after reset release.
    n = (pll_rst0 === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && pll_rst0 === 1'b1; i++) begin
      step(0, 0, 0, 0, 0);
      if (pll_rst0 === 1'b1) n++;
    end
    chk("rst_hold_len", 0, n, 4);
    repeat (6) step(0, 0, 0, 0, 0);
    k = cyc;
    for (int i = 0; i < 40 && lock0 !== 1'b1; i++) step(1, 0, 0, 0, 0);
    chk("lock_latency", 0, lock0_rise - k, S + 2);
    chk("clean_icpsel", 0, icp0, 6'd16);
    chk("clean_retry", 0, rc0, 2'd0);

    // Loss of lock and automatic relock.
    repeat (3) step(1, 0, 0, 0, 0);
    m = cyc;
    n = 0;
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      if (pll_rst0 === 1'b1) n++;
    end
    for (int i = 0; i < 40 && lock0 !== 1'b1; i++) begin
      step(1, 0, 0, 0, 0);
      if (pll_rst0 === 1'b1) n++;
    end
    chk("loss_latency", 0, lock0_fall - m, 2);
    chk("loss_rst_len", 0, n, 4);
    chk("lost_cnt_1", 0, lost0, 8'd1);
    chk("relock", 0, lock0, 1'b1);
    chk("relock_icp", 0, icp0, 6'd16);

    // Glitch during qualification: 5 high, 1 low, then high.
    r = cyc;
    step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("glitch_no_lock", 0, lock0, 1'b0);
    for (int i = 0; i < 30 && lock0 !== 1'b1; i++) step(1, 0, 0, 0, 0);
    chk("glitch_latency", 0, lock0_rise - r, 21);

    // Retries exhausted, then restart.
    step(0, 0, 0, 1, 0);
    icp_at1 = -1; icp_at2 = -1;
    for (int i = 0; i < 150 && fail0 !== 1'b1; i++) begin
      step(0, 0, 0, 0, 0);
      if (rc0 === 2'd1 && icp_at1 < 0) icp_at1 = icp0;
      if (rc0 === 2'd2 && icp_at2 < 0) icp_at2 = icp0;
    end
    chk("retry1_icp", 0, icp_at1, 20);
    chk("retry2_icp", 0, icp_at2, 24);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("fail_sticky", 0, fail0, 1'b1);
    chk("fail_pll_rst", 0, pll_rst0, 1'b1);
    chk("sat_icpsel", 1, icp1, 6'd63);
    chk("sat_lpfres", 1, lpf1, 3'd3);
    chk("sat_fail", 1, fail1, 1'b1);
    step(0, 0, 0, 1, 0);
    chk("restart_icp", 0, icp0, 6'd16);
    chk("restart_fail", 0, fail0, 1'b0);
    n = (pll_rst0 === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && pll_rst0 === 1'b1; i++) begin
      step(0, 0, 0, 0, 0);
      if (pll_rst0 === 1'b1) n++;
    end
    chk("restart_rst_len", 0, n, 4);

    // Synchronous reset while qualifying.
    repeat (5) step(1, 0, 0, 0, 0);
    chk("pre_reset_lost", 0, lost0, 8'd1);
    chk("pre_reset_rst", 0, pll_rst0, 1'b0);
    step(1, 0, 1, 0, 0);
    chk("qrst_pll_rst", 0, pll_rst0, 1'b1);
    chk("qrst_lost", 0, lost0, 8'd0);
    chk("qrst_lock", 0, lock0, 1'b0);

    // Synchronous reset while locked.
    for (int i = 0; i < 40 && lock0 !== 1'b1; i++) step(1, 0, 0, 0, 0);
    chk("pre_lrst_lock", 0, lock0, 1'b1);
    step(1, 0, 1, 0, 0);
    chk("lrst_lock", 0, lock0, 1'b0);
    chk("lrst_pll_rst", 0, pll_rst0, 1'b1);
    chk("lrst_icp", 0, icp0, 6'd16);

    // Randomised run-length lock patterns with occasional restart/reset.
    run0 = 0; run1 = 0; v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (run0 == 0) begin v0 = 1'($urandom_range(0, 1)); run0 = $urandom_range(1, 30); end
      if (run1 == 0) begin v1 = 1'($urandom_range(0, 1)); run1 = $urandom_range(1, 30); end
      run0--; run1--;
      step(v0, v1, ($urandom_range(0, 249) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
